processador_multiciclo_param: RTL
=================================

PROCESSADOR_MULTICICLO_PARAM -- requirements
Module: processador_multiciclo_param

Interface
REQ-001 Parameter DATA_W, default 16, data/register/bus width in bits; legal range 9..32.
REQ-002 Parameter SIGNED_SLT, default 0, comparison mode of slt: 0 unsigned, 1 two's-complement.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Resetn  input  1  reset; synchronous and active-low.
REQ-005 DIN  input  DATA_W  instruction word in T0; immediate operand in T1 of mvi.
REQ-006 Run  input  1  start request; sampled only in T0.
REQ-007 Done  output  1  high for exactly the final cycle of each instruction.
REQ-008 BusWires  output  DATA_W  internal bus value driven this cycle.
REQ-009 Tstep  output  2  current step: 0=T0 … 3=T3.

Function
REQ-010 Instruction fields: DIN[8:6] opcode, DIN[5:3] Rx (destination/first operand), DIN[2:0] Ry (source); DIN[DATA_W-1:9] ignored in T0.
REQ-011 State: eight registers R0..R7 (DATA_W), IR (9 bits), A (DATA_W), G (DATA_W), Tstep counter.
REQ-012 Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 mvnz, 101 and, 110 slt, 111 nop.
REQ-013 T0: if Run=1, IR <= DIN[8:0] and Tstep -> T1; if Run=0, stay in T0 with IR unchanged; BusWires=0, Done=0.
REQ-014 T1 mv: BusWires=R[Ry], R[Rx] <= BusWires, Done=1, next T0.
REQ-015 T1 mvi: BusWires=DIN, R[Rx] <= DIN, Done=1, next T0.
REQ-016 T1 mvnz: BusWires=R[Ry]; R[Rx] written only if G != 0; Done=1 either way; next T0.
REQ-017 T1 nop: BusWires=0, no register write, Done=1, next T0.
REQ-018 T1 add/sub/and/slt: BusWires=R[Rx], A <= BusWires, Done=0, next T2.
REQ-019 T2: BusWires=R[Ry]; G <= A+Bus (add), A-Bus (sub), A&Bus (and), {0…,A<Bus} (slt, per SIGNED_SLT); next T3.
REQ-020 T3: BusWires=G, R[Rx] <= G, Done=1, next T0.
REQ-021 add/sub wrap modulo 2^DATA_W; no carry/overflow state kept.
REQ-022 Latency: mv/mvi/mvnz/nop 2 cycles incl. T0; ALU ops 4 cycles; Done combinational from Tstep and IR.
REQ-023 Run outside T0 ignored; Run held high through Done starts next instruction in the cycle after Done.
REQ-024 Rx=Ry legal: add R3,R3 yields 2·R3; write-back seen next cycle.
REQ-025 G only changes in T2; mvnz tests G value at T1 start (last ALU result).
REQ-026 Exactly one bus source per cycle; no multi-driver condition in any step.

Reset
REQ-027 Resetn=0 at a rising edge: Tstep=T0, R0..R7=0, IR=0, A=0, G=0 next cycle; Done=0, BusWires=0.
REQ-028 Reset has priority over any step, including mid-instruction; no register write from the aborted step.
REQ-029 Run sampled at the first edge with Resetn=1 if in T0.

Verification
REQ-030 Reset, mvi R1 (DIN=0x0048 then 0x1234), mv R0,R1 (0x0001) -> T1 BusWires=0x1234, Done=1, R0=0x1234, 4 cycles total.
REQ-031 mvi R2=0xFFFF, mvi R3=0x0001, add R2,R3 (0x0093) -> T3 BusWires=0x0000, R2=0x0000, Done only in T3.
REQ-032 R4=0x0005, R5=0x0007, sub R4,R5 -> R4=0xFFFE; slt R4,R5 unsigned -> R4=0x0000; SIGNED_SLT=1 -> R4=0x0001.
REQ-033 G=0 after sub of equals, mvnz R6,R1 -> R6 unchanged, Done=1; after G!=0, mvnz R6,R1 -> R6=R1.
REQ-034 Resetn=0 during T2 of add -> next cycle Tstep=0, all registers 0, Done=0, no write-back.
REQ-035 Run held 1 across back-to-back mv instructions -> Done pulses every 2nd cycle; DATA_W=9 build passes REQ-030 with 0x0034 immediate.

Source files
------------

// File: rtl/processador_multiciclo_param.sv
// Multicycle 8-register processor: one shared bus, IR/A/G staging registers,
// and a T0..T3 step counter driving mv/mvi/mvnz/nop and four ALU operations.
module processador_multiciclo_param #(
   parameter int unsigned DATA_W     = 16,
   parameter bit          SIGNED_SLT = 1'b0
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic [DATA_W-1:0] DIN,
   input  logic              Run,
   output logic              Done,
   output logic [DATA_W-1:0] BusWires,
   output logic [1:0]        Tstep
);

   localparam int unsigned IR_W  = 9;
   localparam int unsigned REG_N = 8;
   localparam int unsigned SEL_W = 3;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } tstep_e;

   typedef enum logic [2:0] {
      OP_MV   = 3'b000,
      OP_MVI  = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_MVNZ = 3'b100,
      OP_AND  = 3'b101,
      OP_SLT  = 3'b110,
      OP_NOP  = 3'b111
   } opcode_e;

   typedef enum logic [2:0] {
      BUS_ZERO = 3'd0,
      BUS_DIN  = 3'd1,
      BUS_RX   = 3'd2,
      BUS_RY   = 3'd3,
      BUS_G    = 3'd4
   } bus_sel_e;

   tstep_e            tstep_q, tstep_d;
   logic [IR_W-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] g_q, g_d;
   logic [DATA_W-1:0] regs_q [REG_N];

   opcode_e           opcode;
   logic [SEL_W-1:0]  rx;
   logic [SEL_W-1:0]  ry;
   logic [DATA_W-1:0] rx_val;
   logic [DATA_W-1:0] ry_val;
   logic [DATA_W-1:0] alu_res;
   logic              slt_lt;
   bus_sel_e          bus_sel;
   logic              reg_we;

   assign opcode = opcode_e'(ir_q[8:6]);
   assign rx     = ir_q[5:3];
   assign ry     = ir_q[2:0];
   assign rx_val = regs_q[rx];
   assign ry_val = regs_q[ry];
   assign Tstep  = tstep_q;

   // ALU result for T2; the second operand is the bus value R[Ry]
   always_comb begin
      slt_lt  = SIGNED_SLT ? ($signed(a_q) < $signed(ry_val)) : (a_q < ry_val);
      alu_res = '0;
      case (opcode)
         OP_ADD:  alu_res = a_q + ry_val;
         OP_SUB:  alu_res = a_q - ry_val;
         OP_AND:  alu_res = a_q & ry_val;
         OP_SLT:  alu_res = DATA_W'(slt_lt);
         default: alu_res = '0;
      endcase
   end

   // Step sequencing, bus source selection and write enables
   always_comb begin
      tstep_d = tstep_q;
      ir_d    = ir_q;
      a_d     = a_q;
      g_d     = g_q;
      bus_sel = BUS_ZERO;
      reg_we  = 1'b0;
      Done    = 1'b0;
      case (tstep_q)
         T0: begin
            if (Run) begin
               ir_d    = DIN[IR_W-1:0];
               tstep_d = T1;
            end
         end
         T1: begin
            case (opcode)
               OP_MV: begin
                  bus_sel = BUS_RY;
                  reg_we  = 1'b1;
                  Done    = 1'b1;
                  tstep_d = T0;
               end
               OP_MVI: begin
                  bus_sel = BUS_DIN;
                  reg_we  = 1'b1;
                  Done    = 1'b1;
                  tstep_d = T0;
               end
               OP_MVNZ: begin
                  bus_sel = BUS_RY;
                  reg_we  = (g_q != '0);
                  Done    = 1'b1;
                  tstep_d = T0;
               end
               OP_NOP: begin
                  Done    = 1'b1;
                  tstep_d = T0;
               end
               default: begin
                  bus_sel = BUS_RX;
                  a_d     = rx_val;
                  tstep_d = T2;
               end
            endcase
         end
         T2: begin
            bus_sel = BUS_RY;
            g_d     = alu_res;
            tstep_d = T3;
         end
         T3: begin
            bus_sel = BUS_G;
            reg_we  = 1'b1;
            Done    = 1'b1;
            tstep_d = T0;
         end
         default: tstep_d = T0;
      endcase
   end

   // Single bus multiplexer: exactly one source per cycle
   always_comb begin
      BusWires = '0;
      case (bus_sel)
         BUS_DIN: BusWires = DIN;
         BUS_RX:  BusWires = rx_val;
         BUS_RY:  BusWires = ry_val;
         BUS_G:   BusWires = g_q;
         default: BusWires = '0;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         tstep_q <= T0;
         ir_q    <= '0;
         a_q     <= '0;
         g_q     <= '0;
         for (int i = 0; i < REG_N; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         tstep_q <= tstep_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         g_q     <= g_d;
         if (reg_we) begin
            regs_q[rx] <= BusWires;
         end
      end
   end

endmodule
